div_unit: RTL and testbench

//  Multi-cycle 32-bit radix-2 restoring divider for DIV/DIVU, serving the execute stage.
//  The execute stage issues operands with i_start and stalls (its stall request to the

---
 rtl/div_unit.sv | 165 ++++++++++++++++
 tb/tb_div_unit.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU.
// The execute stage holds i_start until o_ready and then drops it. The result
// is {remainder, quotient}, sign-corrected for DIV. A zero divisor gives a zero
// result after a short BYZERO detour and does not trap.
module div_unit #(
    parameter int N_REG = 32,
    parameter int N_CNT = 6
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_signed,
    input  logic [N_REG-1:0]     i_opdata_0,
    input  logic [N_REG-1:0]     i_opdata_1,
    input  logic                 i_start,
    input  logic                 i_annul,
    output logic [2*N_REG-1:0]   o_result,
    output logic                 o_ready
);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [N_CNT-1:0] cnt;
    logic [N_REG-1:0] rem;
    logic [N_REG-1:0] quo;
    logic [N_REG-1:0] divisor_abs;
    logic             neg_quo;
    logic             neg_rem;

    logic             dividend_neg;
    logic             divisor_neg;
    logic [N_REG-1:0] dividend_abs_in;
    logic [N_REG-1:0] divisor_abs_in;
    logic             divisor_zero;
    logic [N_REG:0]   rem_shift;
    logic [N_REG-1:0] rem_diff;
    logic             rem_ge;
    logic [N_REG-1:0] rem_next;
    logic [N_REG-1:0] quo_next;
    logic [N_REG-1:0] quo_final;
    logic [N_REG-1:0] rem_final;
    logic             last_iter;

    // Operand magnitudes and sign flags, used only when a request is accepted in FREE.
    // The most negative value keeps its bit pattern, which reads correctly as unsigned.
    always_comb begin
        dividend_neg    = i_signed & i_opdata_0[N_REG-1];
        divisor_neg     = i_signed & i_opdata_1[N_REG-1];
        dividend_abs_in = dividend_neg ? (-i_opdata_0) : i_opdata_0;
        divisor_abs_in  = divisor_neg  ? (-i_opdata_1) : i_opdata_1;
        divisor_zero    = (i_opdata_1 == '0);
    end

    // One restoring step. The compare is one bit wider so the shifted-out bit is not lost.
    always_comb begin
        rem_shift = {rem, quo[N_REG-1]};
        rem_ge    = (rem_shift >= {1'b0, divisor_abs});
        rem_diff  = rem_shift[N_REG-1:0] - divisor_abs;
        rem_next  = rem_ge ? rem_diff : rem_shift[N_REG-1:0];
        quo_next  = {quo[N_REG-2:0], rem_ge};
        quo_final = neg_quo ? (-quo_next) : quo_next;
        rem_final = neg_rem ? (-rem_next) : rem_next;
        last_iter = (cnt == N_CNT'(N_REG - 1));
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= FREE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode for the start/annul handshake and the iteration count.
    always_comb begin
        state_next = state;
        case (state)
            FREE: begin
                if (i_start && !i_annul) begin
                    state_next = divisor_zero ? BYZERO : ON;
                end
            end
            BYZERO: begin
                state_next = END;
            end
            ON: begin
                if (i_annul) begin
                    state_next = FREE;
                end else if (last_iter) begin
                    state_next = END;
                end
            end
            END: begin
                if (!i_start) begin
                    state_next = FREE;
                end
            end
            default: begin
                state_next = FREE;
            end
        endcase
    end

    // Datapath: latch operands, iterate, and load or clear the result register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt         <= '0;
            rem         <= '0;
            quo         <= '0;
            divisor_abs <= '0;
            neg_quo     <= 1'b0;
            neg_rem     <= 1'b0;
            o_result    <= '0;
        end else begin
            case (state)
                FREE: begin
                    o_result <= '0;
                    if (i_start && !i_annul && !divisor_zero) begin
                        quo         <= dividend_abs_in;
                        rem         <= '0;
                        divisor_abs <= divisor_abs_in;
                        neg_quo     <= dividend_neg ^ divisor_neg;
                        neg_rem     <= dividend_neg;
                        cnt         <= '0;
                    end
                end
                BYZERO: begin
                    o_result <= '0;
                end
                ON: begin
                    if (i_annul) begin
                        o_result <= '0;
                        cnt      <= '0;
                    end else begin
                        rem <= rem_next;
                        quo <= quo_next;
                        cnt <= cnt + N_CNT'(1);
                        if (last_iter) begin
                            o_result <= {rem_final, quo_final};
                        end
                    end
                end
                END: begin
                    if (!i_start) begin
                        o_result <= '0;
                    end
                end
                default: begin
                    o_result <= '0;
                end
            endcase
        end
    end

    assign o_ready = (state == END);

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed test of div_unit with hand-computed quotient/remainder
// pairs, handshake latency, END hold, annul and reset-in-flight behaviour.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        sgn;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    int total;
    int bad;

    div_unit #(.N_REG(32), .N_CNT(6)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_signed   (sgn),
        .i_opdata_0 (op_a),
        .i_opdata_1 (op_b),
        .i_start    (start),
        .i_annul    (annul),
        .o_result   (result),
        .o_ready    (ready)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic [31:0] a, input logic [31:0] b,
                                 input logic st, input logic an);
        sgn   = s;
        op_a  = a;
        op_b  = b;
        start = st;
        annul = an;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue a divide, scramble the operands after acceptance, wait (bounded) for
    // ready, check latency and result, then drop start and check the clear.
    task automatic runDiv(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_q, input logic [31:0] exp_r,
                          input int exp_lat, input string tag);
        int cycles;
        applyStimulus(s, a, b, 1'b1, 1'b0);
        tick();
        cycles = 1;
        applyStimulus(~s, ~a, b ^ 32'h0000_0F0F, 1'b1, 1'b0);
        while (!ready && cycles < 60) begin
            tick();
            cycles++;
        end
        checkOutput({tag, "_lat"}, 64'(cycles), 64'(exp_lat));
        checkOutput({tag, "_res"}, result, {exp_r, exp_q});
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        checkOutput({tag, "_rdy_clr"}, 64'(ready), 64'd0);
        checkOutput({tag, "_res_clr"}, result, 64'd0);
    endtask

    // Directed sequence.
    initial begin
        logic [63:0] held;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        applyStimulus(1'b0, 32'd100, 32'd7, 1'b1, 1'b0);
        tick();
        tick();
        checkOutput("reset_ready", 64'(ready), 64'd0);
        checkOutput("reset_result", result, 64'd0);
        rst = 1'b0;
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();

        runDiv(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, "divu_100_7");
        runDiv(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, "div_m7_2");
        runDiv(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33, "div_7_m2");
        runDiv(1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 33, "divu_big_2");
        runDiv(1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 33, "div_m100_7");
        runDiv(1'b0, 32'd5, 32'd0, 32'd0, 32'd0, 2, "divu_by_zero");
        runDiv(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33, "div_min_m1");
        runDiv(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 33, "divu_max_1");
        runDiv(1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 32'h7FFF_FFFE, 33, "divu_max_half");

        // Start held in END for five cycles, annul raised too: result must not move.
        runDiv(1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 33, "divu_1000_3");
        applyStimulus(1'b0, 32'd100, 32'd7, 1'b1, 1'b0);
        for (int i = 0; i < 33; i++) tick();
        held = result;
        checkOutput("hold_first", held, {32'd2, 32'd14});
        annul = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("hold_ready", 64'(ready), 64'd1);
            checkOutput("hold_result", result, {32'd2, 32'd14});
        end
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        checkOutput("hold_drop_ready", 64'(ready), 64'd0);
        checkOutput("hold_drop_result", result, 64'd0);

        // Annul after ten iterations, then a fresh divide on normal timing.
        applyStimulus(1'b0, 32'd1000, 32'd3, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 10; i++) tick();
        applyStimulus(1'b0, 32'd1000, 32'd3, 1'b0, 1'b1);
        tick();
        checkOutput("annul_ready", 64'(ready), 64'd0);
        checkOutput("annul_result", result, 64'd0);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 25; i++) begin
            tick();
            checkOutput("annul_quiet", 64'(ready), 64'd0);
        end
        runDiv(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33, "divu_9_3");

        // Reset in the middle of an iteration run.
        applyStimulus(1'b0, 32'd100, 32'd7, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) tick();
        rst = 1'b1;
        tick();
        checkOutput("rst_mid_ready", 64'(ready), 64'd0);
        checkOutput("rst_mid_result", result, 64'd0);
        rst = 1'b0;
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            tick();
            checkOutput("rst_quiet", 64'(ready), 64'd0);
        end
        runDiv(1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 33, "divu_50_5");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
